alu_result_queue: RTL and testbench

//  Buffers the ALU's combinational outputs (result, carryout, zero, overflow) with the issuing

---
 rtl/alu_result_queue.sv | 137 +++++++++++++
 tb/tb_alu_result_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// Result/status FIFO between the 32-bit ALU and a stalling consumer, with sticky carry/overflow.
// Optional same-cycle bypass when empty: define ALU_RESULT_QUEUE_BYPASS_EN.
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_carryout,
    input  logic                       in_zero,
    input  logic                       in_overflow,
    input  logic [2:0]                 in_command,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carryout,
    output logic                       out_zero,
    output logic                       out_overflow,
    output logic [2:0]                 out_command,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_carry,
    output logic                       sticky_overflow,
    input  logic                       sticky_clear
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carryout;
        logic             zero;
        logic             overflow;
        logic [2:0]       command;
    } entry_t;

    entry_t             entry_q [DEPTH];
    entry_t             in_entry;
    entry_t             out_entry;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sticky_carry_q, sticky_carry_d;
    logic               sticky_overflow_q, sticky_overflow_d;
    logic               accept;
    logic               store;
    logic               pop;
    logic               stored_valid;
    logic               bypass;

    assign in_entry = '{result: in_result, carryout: in_carryout, zero: in_zero,
                        overflow: in_overflow, command: in_command};

    // in_ready depends only on the registered count, never on out_ready
    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign stored_valid = (count_q != '0);
    assign accept       = in_valid && in_ready;

`ifdef ALU_RESULT_QUEUE_BYPASS_EN
    assign bypass = !stored_valid && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = stored_valid || bypass;
    assign pop       = stored_valid && out_ready;
    // A bypassed entry taken by the consumer the same cycle is never written
    assign store     = accept && !(bypass && out_ready);

    always_comb begin
        out_entry = '0;
        if (stored_valid) begin
            out_entry = entry_q[rd_ptr_q];
        end else if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign out_result   = out_entry.result;
    assign out_carryout = out_entry.carryout;
    assign out_zero     = out_entry.zero;
    assign out_overflow = out_entry.overflow;
    assign out_command  = out_entry.command;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Setting by an accepted entry takes priority over a same-cycle clear
    always_comb begin
        sticky_carry_d    = (sticky_carry_q && !sticky_clear) || (accept && in_carryout);
        sticky_overflow_d = (sticky_overflow_q && !sticky_clear) || (accept && in_overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            sticky_carry_q    <= 1'b0;
            sticky_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            sticky_carry_q    <= sticky_carry_d;
            sticky_overflow_q <= sticky_overflow_d;
        end
    end

    // Storage needs no reset: it is only visible through out_* while count is nonzero
    always_ff @(posedge clk) begin
        if (store) begin
            entry_q[wr_ptr_q] <= in_entry;
        end
    end

    assign count           = count_q;
    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_overflow_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized and directed bench for alu_result_queue against a queue-based reference model.
module tb_alu_result_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic             in_carryout = 1'b0;
    logic             in_zero = 1'b0;
    logic             in_overflow = 1'b0;
    logic [2:0]       in_command = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             out_carryout;
    logic             out_zero;
    logic             out_overflow;
    logic [2:0]       out_command;
    logic [2:0]       count;
    logic             sticky_carry;
    logic             sticky_overflow;
    logic             sticky_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_carryout(in_carryout), .in_zero(in_zero), .in_overflow(in_overflow),
        .in_command(in_command),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
        .out_command(out_command), .count(count),
        .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow),
        .sticky_clear(sticky_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             z;
        logic             o;
        logic [2:0]       cmd;
    } ent_t;

    ent_t q[$];
    logic m_sc = 1'b0;
    logic m_so = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bypass_now();
`ifdef ALU_RESULT_QUEUE_BYPASS_EN
        return (q.size() == 0) && in_valid;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: a plain queue of accepted entries plus two sticky flags
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_sc = 1'b0;
            m_so = 1'b0;
        end else begin
            logic acc, consumed;
            acc      = in_valid && (q.size() != DEPTH);
            consumed = bypass_now() && out_ready;
            m_sc = (m_sc && !sticky_clear) || (acc && in_carryout);
            m_so = (m_so && !sticky_clear) || (acc && in_overflow);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc && !consumed) q.push_back('{in_result, in_carryout, in_zero, in_overflow, in_command});
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            ent_t e;
            logic ev;
            e  = '0;
            ev = (q.size() != 0) || bypass_now();
            if (q.size() != 0) e = q[0];
            else if (bypass_now()) e = '{in_result, in_carryout, in_zero, in_overflow, in_command};
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            chk("count", 64'(count), 64'(q.size()));
            chk("out_data", 64'({out_result, out_carryout, out_zero, out_overflow, out_command}), 64'(e));
            chk("sticky", 64'({sticky_carry, sticky_overflow}), 64'({m_sc, m_so}));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic c, input logic z,
                         input logic o, input logic [2:0] cmd);
        in_valid = v; in_result = r; in_carryout = c; in_zero = z; in_overflow = o; in_command = cmd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'b000);
        sticky_clear = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // Fill to full, refuse a fifth push, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, 3'b010);
            cyc();
        end
        idle();
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 3'b010);
        cyc();
        idle();
        chk("refused_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_result", 64'(out_result), 64'(i));
            cyc();
        end
        chk("drained_count", 64'(count), 64'd0);
        chk("drained_out_result", 64'(out_result), 64'd0);

        // Head held stable under stall
        out_ready = 1'b0;
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3'b001);
        cyc();
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("stall_result", 64'(out_result), 64'hDEADBEEF);
            chk("stall_cmd", 64'(out_command), 64'd1);
            chk("stall_zero", 64'(out_zero), 64'd0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Simultaneous push and pop at count 2, across pointer wrap
        drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 3'b000); cyc();
        drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 3'b000); cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] exp_head;
            drive(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0, 3'b000);
            exp_head = (k == 0) ? 32'hA0 : (k == 1) ? 32'hA1 : 32'h100 + 32'(k - 2);
            chk("pp_head", 64'(out_result), 64'(exp_head));
            cyc();
            chk("pp_count", 64'(count), 64'd2);
        end
        idle();
        cyc(); cyc();
        chk("pp_empty", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Sticky bits: set, set-wins-over-clear, clear alone
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 3'b010);
        cyc();
        idle();
        chk("sticky_carry_set", 64'(sticky_carry), 64'd1);
        drive(1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 3'b010);
        sticky_clear = 1'b1;
        cyc();
        idle();
        chk("sticky_ovf_wins", 64'(sticky_overflow), 64'd1);
        chk("sticky_carry_cleared", 64'(sticky_carry), 64'd0);
        sticky_clear = 1'b1;
        cyc();
        idle();
        chk("sticky_both_clear", 64'({sticky_carry, sticky_overflow}), 64'd0);
        out_ready = 1'b1;
        cyc(); cyc();
        chk("sticky_drained", 64'(count), 64'd0);

        // Push into empty queue with consumer ready
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 3'b000);
        #1;
`ifdef ALU_RESULT_QUEUE_BYPASS_EN
        chk("bypass_same_valid", 64'(out_valid), 64'd1);
        chk("bypass_same_result", 64'(out_result), 64'h5);
`else
        chk("nobypass_same_valid", 64'(out_valid), 64'd0);
`endif
        cyc();
        idle();
        out_ready = 1'b0;
        #1;
`ifdef ALU_RESULT_QUEUE_BYPASS_EN
        chk("bypass_count", 64'(count), 64'd0);
        chk("bypass_next_valid", 64'(out_valid), 64'd0);
`else
        chk("nobypass_next_valid", 64'(out_valid), 64'd1);
        chk("nobypass_next_result", 64'(out_result), 64'h5);
`endif
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            drive(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), r == 32'h0,
                  1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
            out_ready    = ($urandom_range(0, 9) < 6);
            sticky_clear = ($urandom_range(0, 9) == 0);
            cyc();
        end

        // Reset mid-stream with three entries queued and sticky set
        idle();
        out_ready = 1'b0;
        cyc(); cyc();
        out_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc(); cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 1'b1, 1'b0, 1'b1, 3'b110);
            cyc();
        end
        idle();
        chk("pre_reset_count", 64'(count), 64'd3);
        #1 reset = 1'b1;
        #1;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_sticky", 64'({sticky_carry, sticky_overflow}), 64'd0);
        chk("midreset_out_data", 64'({out_result, out_command}), 64'd0);
        cyc();
        reset = 1'b0;
        cyc(); cyc();
        chk("post_reset_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
